// File: rtl/uart_fifo_wr_ctrl.sv
// rtl/uart_fifo_wr_ctrl.sv - write-domain pointer, full/level and overflow controller for the UART async FIFO
module uart_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  i_fifo_wr_ctrl_clk,
  input  logic                  i_fifo_wr_ctrl_rst_n,
  input  logic                  i_fifo_wr_ctrl_winc,
  input  logic                  i_fifo_wr_ctrl_clr_ovf,
  input  logic [ADDR_WIDTH:0]   i_fifo_wr_ctrl_rgray,
  output logic [ADDR_WIDTH:0]   o_fifo_wr_ctrl_wgray,
  output logic [ADDR_WIDTH-1:0] o_fifo_wr_ctrl_waddr,
  output logic                  o_fifo_wr_ctrl_wen,
  output logic                  o_fifo_wr_ctrl_full,
  output logic                  o_fifo_wr_ctrl_afull,
  output logic [ADDR_WIDTH:0]   o_fifo_wr_ctrl_level,
  output logic                  o_fifo_wr_ctrl_ovf
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LEVEL);

  logic [SYNC_STAGES*PW-1:0] sync_q;
  logic [PW-1:0] rq;
  logic [PW-1:0] rbin;
  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] level;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] level_next;
  logic          full;
  logic          afull;
  logic          ovf;
  logic          full_next;
  logic          afull_next;
  logic          ovf_next;
  logic          wen;

  // Oldest stage sits in the top slice of the packed chain.
  always_ff @(posedge i_fifo_wr_ctrl_clk or negedge i_fifo_wr_ctrl_rst_n) begin
    if (!i_fifo_wr_ctrl_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[(SYNC_STAGES-1)*PW-1:0], i_fifo_wr_ctrl_rgray};
    end
  end

  assign rq = sync_q[SYNC_STAGES*PW-1 -: PW];

  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(rq >> i);
    end
  end

  assign wen        = i_fifo_wr_ctrl_winc & ~full;
  assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wen};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign full_next  = (wgray_next == {~rq[PW-1:PW-2], rq[PW-3:0]});
  assign level_next = wbin_next - rbin;
  assign afull_next = (level_next >= AFULL_THR);

  // A new overflow in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_next = ovf;
    if (i_fifo_wr_ctrl_winc && full) begin
      ovf_next = 1'b1;
    end else if (i_fifo_wr_ctrl_clr_ovf) begin
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge i_fifo_wr_ctrl_clk or negedge i_fifo_wr_ctrl_rst_n) begin
    if (!i_fifo_wr_ctrl_rst_n) begin
      wbin  <= '0;
      wgray <= '0;
      level <= '0;
      full  <= 1'b0;
      afull <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      wbin  <= wbin_next;
      wgray <= wgray_next;
      level <= level_next;
      full  <= full_next;
      afull <= afull_next;
      ovf   <= ovf_next;
    end
  end

  assign o_fifo_wr_ctrl_wgray = wgray;
  assign o_fifo_wr_ctrl_waddr = wbin[ADDR_WIDTH-1:0];
  assign o_fifo_wr_ctrl_wen   = wen;
  assign o_fifo_wr_ctrl_full  = full;
  assign o_fifo_wr_ctrl_afull = afull;
  assign o_fifo_wr_ctrl_level = level;
  assign o_fifo_wr_ctrl_ovf   = ovf;

endmodule

// File: tb/tb_uart_fifo_wr_ctrl.sv
// tb/tb_uart_fifo_wr_ctrl.sv - self-checking bench for uart_fifo_wr_ctrl (default and wide parameter sets)
module tb_uart_fifo_wr_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       winc = 1'b0, clr = 1'b0;
  logic [3:0] rgray = '0;
  logic [3:0] wgray, level;
  logic [2:0] waddr;
  logic       wen, full, afull, ovf;

  logic       winc2 = 1'b0, clr2 = 1'b0;
  logic [4:0] rgray2 = '0;
  logic [4:0] wgray2, level2;
  logic [3:0] waddr2;
  logic       wen2, full2, afull2, ovf2;

  uart_fifo_wr_ctrl dut (
    .i_fifo_wr_ctrl_clk     (clk),
    .i_fifo_wr_ctrl_rst_n   (rst_n),
    .i_fifo_wr_ctrl_winc    (winc),
    .i_fifo_wr_ctrl_clr_ovf (clr),
    .i_fifo_wr_ctrl_rgray   (rgray),
    .o_fifo_wr_ctrl_wgray   (wgray),
    .o_fifo_wr_ctrl_waddr   (waddr),
    .o_fifo_wr_ctrl_wen     (wen),
    .o_fifo_wr_ctrl_full    (full),
    .o_fifo_wr_ctrl_afull   (afull),
    .o_fifo_wr_ctrl_level   (level),
    .o_fifo_wr_ctrl_ovf     (ovf)
  );

  uart_fifo_wr_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(3), .AFULL_LEVEL(16)) dut2 (
    .i_fifo_wr_ctrl_clk     (clk),
    .i_fifo_wr_ctrl_rst_n   (rst_n),
    .i_fifo_wr_ctrl_winc    (winc2),
    .i_fifo_wr_ctrl_clr_ovf (clr2),
    .i_fifo_wr_ctrl_rgray   (rgray2),
    .o_fifo_wr_ctrl_wgray   (wgray2),
    .o_fifo_wr_ctrl_waddr   (waddr2),
    .o_fifo_wr_ctrl_wen     (wen2),
    .o_fifo_wr_ctrl_full    (full2),
    .o_fifo_wr_ctrl_afull   (afull2),
    .o_fifo_wr_ctrl_level   (level2),
    .o_fifo_wr_ctrl_ovf     (ovf2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    winc = 0; clr = 0; rgray = '0;
    winc2 = 0; clr2 = 0; rgray2 = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  typedef struct {
    logic       winc;
    logic       clr;
    logic       exp_wen;
    int         lvl;
    logic       af;
    logic       fu;
    logic       ov;
    int         wa;
    logic [3:0] wg;
  } vec_t;

  vec_t tbl[14];

  // Write-domain model: counts of accepted writes and reads, with reads seen SYNC_STAGES edges late.
  int   wr_total, rd_cnt, rd_seen, m_level;
  logic m_ovf, m_full, acc;
  int   rd_q[$];
  logic [3:0] prev_wgray;

  initial begin
    tbl[0]  = '{1, 0, 1, 1, 0, 0, 0, 1, 4'b0001};
    tbl[1]  = '{1, 0, 1, 2, 0, 0, 0, 2, 4'b0011};
    tbl[2]  = '{1, 0, 1, 3, 0, 0, 0, 3, 4'b0010};
    tbl[3]  = '{1, 0, 1, 4, 0, 0, 0, 4, 4'b0110};
    tbl[4]  = '{1, 0, 1, 5, 0, 0, 0, 5, 4'b0111};
    tbl[5]  = '{1, 0, 1, 6, 1, 0, 0, 6, 4'b0101};
    tbl[6]  = '{1, 0, 1, 7, 1, 0, 0, 7, 4'b0100};
    tbl[7]  = '{1, 0, 1, 8, 1, 1, 0, 0, 4'b1100};
    tbl[8]  = '{1, 0, 0, 8, 1, 1, 1, 0, 4'b1100};
    tbl[9]  = '{1, 0, 0, 8, 1, 1, 1, 0, 4'b1100};
    tbl[10] = '{0, 1, 0, 8, 1, 1, 0, 0, 4'b1100};
    tbl[11] = '{1, 0, 0, 8, 1, 1, 1, 0, 4'b1100};
    tbl[12] = '{1, 1, 0, 8, 1, 1, 1, 0, 4'b1100};
    tbl[13] = '{0, 0, 0, 8, 1, 1, 1, 0, 4'b1100};

    do_reset();
    chk("rst_wgray", wgray, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_level", level, 0);
    chk("rst_full",  full,  0);
    chk("rst_afull", afull, 0);
    chk("rst_ovf",   ovf,   0);
    chk("rst_level2", level2, 0);

    // Fill, overflow and clear sequence
    for (int i = 0; i < 14; i++) begin
      winc = tbl[i].winc;
      clr  = tbl[i].clr;
      #1;
      chk($sformatf("tbl%0d_wen", i), wen, tbl[i].exp_wen);
      step();
      chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("tbl%0d_afull", i), afull, tbl[i].af);
      chk($sformatf("tbl%0d_full", i),  full,  tbl[i].fu);
      chk($sformatf("tbl%0d_ovf", i),   ovf,   tbl[i].ov);
      chk($sformatf("tbl%0d_waddr", i), waddr, tbl[i].wa);
      chk($sformatf("tbl%0d_wgray", i), wgray, tbl[i].wg);
    end

    // Release: one read propagates to full/level on the third edge
    winc = 0; clr = 0; rgray = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("rel_full_e%0d", k), full, (k < 3) ? 1 : 0);
      chk($sformatf("rel_level_e%0d", k), level, (k < 3) ? 8 : 7);
    end
    chk("rel_afull", afull, 1);

    // Randomised wrap-around run against the occupancy model
    do_reset();
    wr_total = 0; rd_cnt = 0; m_level = 0; m_ovf = 0;
    rd_q.delete();
    for (int i = 0; i < 2; i++) rd_q.push_back(0);
    for (int c = 0; c < 200; c++) begin
      winc = ($urandom_range(0, 99) < 70);
      clr  = ($urandom_range(0, 99) < 20);
      if (rd_cnt < wr_total && $urandom_range(0, 99) < ((c < 80) ? 30 : 55)) rd_cnt++;
      rgray = gray4(rd_cnt);
      #1;
      m_full = (m_level == 8);
      acc = winc && !m_full;
      chk("rnd_wen", wen, acc);
      prev_wgray = wgray;
      m_ovf = (winc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      wr_total += int'(acc);
      rd_q.push_back(rd_cnt);
      rd_seen = rd_q.pop_front();
      m_level = wr_total - rd_seen;
      step();
      chk("rnd_level", level, m_level);
      chk("rnd_full",  full,  m_level == 8);
      chk("rnd_full_inv", full, level == 8);
      chk("rnd_afull", afull, m_level >= 6);
      chk("rnd_waddr", waddr, wr_total % 8);
      chk("rnd_wgray", wgray, gray4(wr_total));
      chk("rnd_wgray_1bit", $countones(wgray ^ prev_wgray), int'(acc));
      chk("rnd_ovf",   ovf,   m_ovf);
    end
    chk("rnd_wrapped_twice", wr_total >= 32, 1);

    // Wide parameter set: afull and full together at the 16th write, 4-edge release
    do_reset();
    for (int i = 0; i < 16; i++) begin
      winc2 = 1;
      step();
      chk($sformatf("p2_level_w%0d", i + 1), level2, i + 1);
      chk($sformatf("p2_afull_w%0d", i + 1), afull2, (i == 15) ? 1 : 0);
      chk($sformatf("p2_full_w%0d", i + 1),  full2,  (i == 15) ? 1 : 0);
    end
    chk("p2_waddr", waddr2, 0);
    chk("p2_wgray", wgray2, 5'b11000);
    winc2 = 0; rgray2 = 5'b00001;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("p2_rel_full_e%0d", k), full2, (k < 4) ? 1 : 0);
      chk($sformatf("p2_rel_level_e%0d", k), level2, (k < 4) ? 16 : 15);
    end

    // Asynchronous reset after five writes
    do_reset();
    winc = 1;
    for (int i = 0; i < 5; i++) step();
    chk("mid_level_pre", level, 5);
    chk("mid_waddr_pre", waddr, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_wgray", wgray, 0);
    chk("mid_waddr", waddr, 0);
    chk("mid_level", level, 0);
    chk("mid_full",  full,  0);
    chk("mid_afull", afull, 0);
    chk("mid_ovf",   ovf,   0);
    winc = 0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_level", level, 0);
    chk("post_waddr", waddr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
